// File: rtl/timerio_pkg.sv
// Shared register map and control-word layout for the memory-mapped down-counting timer.
package timerio_pkg;
  localparam logic [3:0] TMR_CTRL  = 4'h0;
  localparam logic [3:0] TMR_STAT  = 4'h1;
  localparam logic [3:0] TMR_PRESC = 4'h2;
  localparam logic [3:0] TMR_RLD_H = 4'h4;
  localparam logic [3:0] TMR_RLD_L = 4'h5;
  localparam logic [3:0] TMR_CNT_H = 4'h6;
  localparam logic [3:0] TMR_CNT_L = 4'h7;

  localparam int STAT_OVF = 0;

  // Field order matches CTRL bits [2:0] so a byte slice casts directly.
  typedef struct packed {
    logic reload;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [7:0] ctrl_pack(ctrl_t c);
    return {5'b00000, c};
  endfunction
endpackage

// File: rtl/timerio_if.sv
// CPU-side byte bus of the timer plus its interrupt line.
interface timerio_if;
  logic [3:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;

  modport master (output AD, output DI, output rw, output cs, input DO, input irq);
  modport slave  (input AD, input DI, input rw, input cs, output DO, output irq);
endinterface

// File: rtl/timerio_prescaler.sv
// Clock prescaler: pulses tick once every div+1 enabled cycles; held at zero when disabled.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);
  logic [7:0] pcnt_q, pcnt_d;

  always_comb begin
    tick   = en && (pcnt_q == div);
    pcnt_d = pcnt_q + 8'd1;
    if (!en || clr || tick) pcnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pcnt_q <= 8'd0;
    else      pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/timerio.sv
// 16-bit down-counting timer with periodic/one-shot interrupt and coherent byte-wise count readback.
module timerio
  import timerio_pkg::*;
#(
  parameter logic [7:0]  RST_PRESC  = 8'h00,
  parameter logic [15:0] RST_RELOAD = 16'hFFFF
) (
  input  logic      clk,
  input  logic      rst,
  timerio_if.slave  bus
);
  ctrl_t       ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] rld_q, rld_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tmp_hi_q, tmp_hi_d;
  logic [7:0]  latch_lo_q, latch_lo_d;
  logic [7:0]  do_mux;
  logic        wr_stb, rd_stb, load, tick;

  assign wr_stb = bus.cs && !bus.rw;
  assign rd_stb = bus.cs && bus.rw;
  assign load   = wr_stb && (bus.AD == TMR_CNT_L);

  timer_prescaler u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q.en),
    .clr  (load),
    .div  (presc_q),
    .tick (tick)
  );

  always_comb begin
    ctrl_d     = ctrl_q;
    ovf_d      = ovf_q;
    presc_d    = presc_q;
    rld_d      = rld_q;
    cnt_d      = cnt_q;
    tmp_hi_d   = tmp_hi_q;
    latch_lo_d = latch_lo_q;
    irq_d      = ovf_q && ctrl_q.ie;

    // Clear first so a same-edge underflow re-sets OVF.
    if (wr_stb && bus.AD == TMR_STAT && bus.DI[STAT_OVF]) ovf_d = 1'b0;

    if (load) begin
      cnt_d = {tmp_hi_q, bus.DI};
    end else if (tick) begin
      if (cnt_q != 16'h0000) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        ovf_d = 1'b1;
        if (ctrl_q.reload) cnt_d = rld_q;
        else               ctrl_d.en = 1'b0;
      end
    end

    // Register writes come after the tick so a CTRL write overrides the one-shot stop.
    if (wr_stb) begin
      case (bus.AD)
        TMR_CTRL:  ctrl_d         = ctrl_t'(bus.DI[2:0]);
        TMR_PRESC: presc_d        = bus.DI;
        TMR_RLD_H: rld_d[15:8]    = bus.DI;
        TMR_RLD_L: rld_d[7:0]     = bus.DI;
        TMR_CNT_H: tmp_hi_d       = bus.DI;
        default:   ;
      endcase
    end

    if (rd_stb && bus.AD == TMR_CNT_H) latch_lo_d = cnt_q[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      presc_q    <= RST_PRESC;
      rld_q      <= RST_RELOAD;
      cnt_q      <= 16'h0000;
      tmp_hi_q   <= 8'h00;
      latch_lo_q <= 8'h00;
    end else begin
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      presc_q    <= presc_d;
      rld_q      <= rld_d;
      cnt_q      <= cnt_d;
      tmp_hi_q   <= tmp_hi_d;
      latch_lo_q <= latch_lo_d;
    end
  end

  always_comb begin
    do_mux = 8'h00;
    case (bus.AD)
      TMR_CTRL:  do_mux = ctrl_pack(ctrl_q);
      TMR_STAT:  do_mux = {7'b0000000, ovf_q};
      TMR_PRESC: do_mux = presc_q;
      TMR_RLD_H: do_mux = rld_q[15:8];
      TMR_RLD_L: do_mux = rld_q[7:0];
      TMR_CNT_H: do_mux = cnt_q[15:8];
      TMR_CNT_L: do_mux = latch_lo_q;
      default:   do_mux = 8'h00;
    endcase
  end

  assign bus.DO  = do_mux;
  assign bus.irq = irq_q;
endmodule
